// File: rtl/conv_inst_sequencer.sv
// Instruction sequencer for one 3x3 convolution tile: weight load, activation feed, psum drain.
// Optional drain watchdog enabled by defining SEQ_DRAIN_TIMEOUT_EN.
module conv_inst_sequencer #(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int NIJ     = 36,
    parameter int KIJ     = 9,
    parameter int ADDR_W  = 11,
    parameter int W_BASE  = 0,
    parameter int A_BASE  = 512,
    parameter int P_BASE  = 0,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        ofifo_valid,
    output logic [33:0] inst_q,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_idx,
    output logic        err
);

    localparam int CNT_W = $clog2(NIJ + ROW + COL + 1);

    typedef enum logic [2:0] {IDLE, W_LD, W_KER, A_FEED, DRAIN, DONE} state_t;

    typedef struct packed {
        logic              acc;
        logic              cen_pmem;
        logic              wen_pmem;
        logic [ADDR_W-1:0] a_pmem;
        logic              cen_xmem;
        logic              wen_xmem;
        logic [ADDR_W-1:0] a_xmem;
        logic              ofifo_rd;
        logic              ififo_wr;
        logic              ififo_rd;
        logic              l0_rd;
        logic              l0_wr;
        logic              execute;
        logic              load;
    } inst_t;

    // SRAM enables are active-low, so the quiet word keeps them high.
    localparam inst_t IDLE_WORD = '{cen_pmem: 1'b1, wen_pmem: 1'b1,
                                    cen_xmem: 1'b1, wen_xmem: 1'b1, default: '0};

    state_t            state;
    inst_t             word;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic [3:0]        kij;
    logic              wr_pend;
    logic              drain_rd;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] p_addr;

`ifdef SEQ_DRAIN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] idle_cnt;
    logic            err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign w_addr   = ADDR_W'(W_BASE + int'(kij) * COL + int'(cnt));
    assign a_addr   = ADDR_W'(A_BASE + int'(cnt));
    assign p_addr   = ADDR_W'(P_BASE + int'(out_cnt));
    assign drain_rd = ofifo_valid && (cnt < CNT_W'(NIJ));

    assign inst_q  = word;
    assign busy    = (state != IDLE);
    assign kij_idx = kij;

    // NOTE: all state lives in this one clocked block and uses non-blocking assignments only,
    // so every right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            word    <= IDLE_WORD;
            cnt     <= '0;
            out_cnt <= '0;
            kij     <= '0;
            wr_pend <= 1'b0;
            done    <= 1'b0;
`ifdef SEQ_DRAIN_TIMEOUT_EN
            idle_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: defaults first; a later non-blocking write to the same field in this pass wins.
            word <= IDLE_WORD;
            done <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                cnt     <= '0;
                out_cnt <= '0;
                kij     <= '0;
                wr_pend <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= W_LD;
                            kij   <= '0;
                            cnt   <= '0;
                        end
                    end
                    W_LD: begin
                        if (cnt != CNT_W'(COL)) begin
                            word.cen_xmem <= 1'b0;
                            word.a_xmem   <= w_addr;
                        end
                        // xmem data lands one cycle after the read
                        if (cnt != '0) word.l0_wr <= 1'b1;
                        if (cnt == CNT_W'(COL)) begin
                            state <= W_KER;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    W_KER: begin
                        word.load  <= 1'b1;
                        word.l0_rd <= (cnt < CNT_W'(COL));
                        if (cnt == CNT_W'(ROW + COL - 2)) begin
                            state <= A_FEED;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    A_FEED: begin
                        if (cnt != CNT_W'(NIJ)) begin
                            word.cen_xmem <= 1'b0;
                            word.a_xmem   <= a_addr;
                        end
                        if (cnt != '0) begin
                            word.l0_wr   <= 1'b1;
                            word.l0_rd   <= 1'b1;
                            word.execute <= 1'b1;
                        end
                        if (cnt == CNT_W'(NIJ)) begin
                            state   <= DRAIN;
                            cnt     <= '0;
                            out_cnt <= '0;
                            wr_pend <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DRAIN: begin
                        // cnt counts OFIFO reads, out_cnt counts the pmem writes that follow them
                        word.ofifo_rd <= drain_rd;
                        if (drain_rd) cnt <= cnt + 1'b1;
                        wr_pend <= drain_rd;
                        if (wr_pend) begin
                            word.cen_pmem <= 1'b0;
                            word.wen_pmem <= 1'b0;
                            word.a_pmem   <= p_addr;
                            word.acc      <= (kij != 4'd0);
                            out_cnt       <= out_cnt + 1'b1;
                            if (out_cnt == CNT_W'(NIJ - 1)) begin
                                cnt <= '0;
                                if (kij == 4'(KIJ - 1)) begin
                                    state <= DONE;
                                end else begin
                                    kij   <= kij + 4'd1;
                                    state <= W_LD;
                                end
                            end
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
`ifdef SEQ_DRAIN_TIMEOUT_EN
            if (!abort && state == IDLE && start) err_q <= 1'b0;
            if (abort || state != DRAIN || ofifo_valid) begin
                idle_cnt <= '0;
            end else if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
                err_q    <= 1'b1;
                state    <= IDLE;
                word     <= IDLE_WORD;
                cnt      <= '0;
                out_cnt  <= '0;
                wr_pend  <= 1'b0;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
`endif
        end
    end

endmodule
